// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encodings and the per-result FIFO entry.
// ALU_RES_FIFO_PARITY_EN adds a stored even-parity bit to each entry.
package alu_pkg;
   typedef logic [2:0] alu_op_t;

   localparam alu_op_t OP_ADD = 3'b000;
   localparam alu_op_t OP_SUB = 3'b001;
   localparam alu_op_t OP_AND = 3'b010;
   localparam alu_op_t OP_OR  = 3'b011;
   localparam alu_op_t OP_XOR = 3'b100;
   localparam alu_op_t OP_NOT = 3'b101;

   typedef struct packed {
      logic [7:0] result;
      alu_op_t    op;
      logic       zero;
      logic       neg;
      logic       err;
`ifdef ALU_RES_FIFO_PARITY_EN
      logic       parity;
`endif
   } alu_res_t;

   // 3'b110 and 3'b111 are the only encodings outside ADD..NOT
   function automatic logic op_is_err(alu_op_t op);
      return op[2] & op[1];
   endfunction
endpackage

// File: rtl/alu_result_fifo_if.sv
// ALU-to-writeback result channel: push side and show-ahead pop side.
// ALU_RES_FIFO_PARITY_EN adds out_parity.
interface alu_result_fifo_if;
   import alu_pkg::*;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   alu_op_t    in_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   alu_op_t    out_op;
   logic       out_zero;
   logic       out_neg;
   logic       out_err;
`ifdef ALU_RES_FIFO_PARITY_EN
   logic       out_parity;
`endif

   // master: the environment (ALU issue + writeback consumer)
   modport master (
      output in_valid, in_result, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_err
`ifdef ALU_RES_FIFO_PARITY_EN
      , input out_parity
`endif
   );

   // slave: the FIFO itself
   modport slave (
      input  in_valid, in_result, in_op, out_ready,
      output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_err
`ifdef ALU_RES_FIFO_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/alu_result_fifo_flags.sv
// Combinational entry builder: status flags (and parity under
// ALU_RES_FIFO_PARITY_EN) derived from an ALU result and its opcode.
module alu_res_flags
   import alu_pkg::*;
(
   input  logic [7:0] result,
   input  alu_op_t    op,
   output alu_res_t   ent
);
   always_comb begin
      ent        = '0;
      ent.result = result;
      ent.op     = op;
      ent.zero   = (result == 8'h00);
      ent.neg    = result[7];
      ent.err    = op_is_err(op);
`ifdef ALU_RES_FIFO_PARITY_EN
      ent.parity = ^{op, result};
`endif
   end
endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead result FIFO between the ALU and writeback; flags are captured
// at push. ALU_RES_FIFO_PARITY_EN adds a stored parity bit per entry.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   alu_result_fifo_if.slave bus,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   alu_res_t         mem [DEPTH];
   alu_res_t         wr_ent, head;
   logic             push, pop;

   alu_res_flags u_flags (
      .result (bus.in_result),
      .op     (bus.in_op),
      .ent    (wr_ent)
   );

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   // full blocks the push even if a pop frees a slot this cycle
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage is left unreset; empty masks stale contents
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_ent;
   end

   assign head = empty ? '0 : mem[rd_ptr];

   assign bus.in_ready   = ~full;
   assign bus.out_valid  = ~empty;
   assign bus.out_result = head.result;
   assign bus.out_op     = head.op;
   assign bus.out_zero   = head.zero;
   assign bus.out_neg    = head.neg;
   assign bus.out_err    = head.err;
`ifdef ALU_RES_FIFO_PARITY_EN
   assign bus.out_parity = head.parity;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: expectations queued on accepted
// pushes, compared at the head each cycle and dropped on accepted pops.
module tb_alu_result_fifo;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [7:0] res;
      logic [2:0] op;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] count;
   logic             full, empty;
   int               vectors = 0;
   int               miscompares = 0;
   exp_t             q[$];

   alu_result_fifo_if bus ();

   alu_result_fifo #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic r, input logic [7:0] res, input logic [2:0] op);
      bus.in_valid  = v;
      bus.out_ready = r;
      bus.in_result = res;
      bus.in_op     = op;
      @(posedge clk);
      #1;
   endtask

   // inputs change at posedge+1, so negedge sees what the next edge will act on
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         automatic int sz = q.size();
         chk("count", 32'(count), 32'(sz));
         chk("empty", 32'(empty), 32'(sz == 0));
         chk("full", 32'(full), 32'(sz == DEPTH));
         chk("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(sz > 0));
         if (sz == 0) begin
            chk("idle_result", 32'(bus.out_result), 32'd0);
            chk("idle_fields", 32'({bus.out_op, bus.out_zero, bus.out_neg, bus.out_err}), 32'd0);
         end else begin
            automatic exp_t e = q[0];
            chk("out_result", 32'(bus.out_result), 32'(e.res));
            chk("out_op", 32'(bus.out_op), 32'(e.op));
            chk("out_zero", 32'(bus.out_zero), 32'(e.res == 8'h00));
            chk("out_neg", 32'(bus.out_neg), 32'(e.res[7]));
            chk("out_err", 32'(bus.out_err), 32'(e.op == 3'b110 || e.op == 3'b111));
`ifdef ALU_RES_FIFO_PARITY_EN
            chk("out_parity", 32'(bus.out_parity), 32'(^{e.op, e.res}));
`endif
         end
`ifdef ALU_RES_FIFO_PARITY_EN
         if (sz == 0) chk("idle_parity", 32'(bus.out_parity), 32'd0);
`endif
         if (bus.out_ready && sz > 0) void'(q.pop_front());
         if (bus.in_valid && sz < DEPTH) q.push_back('{res: bus.in_result, op: bus.in_op});
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_result = 8'h00;
      bus.in_op     = 3'b000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      cyc(0, 0, 8'h00, OP_ADD);

      // single push, then pop
      cyc(1, 0, 8'h80, OP_ADD);
      cyc(0, 0, 8'h00, OP_ADD);
      cyc(0, 1, 8'h00, OP_ADD);
      cyc(0, 0, 8'h00, OP_ADD);

      // fill, blocked fifth push, drain plus one pop while empty
      for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), OP_SUB);
      cyc(1, 0, 8'h05, OP_SUB);
      chk("fill_full", 32'(full), 32'd1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, OP_ADD);

      // steady push/pop at count 2 across pointer wrap
      cyc(1, 0, 8'hA0, OP_AND);
      cyc(1, 0, 8'hA1, OP_AND);
      for (int i = 0; i < 6; i++) cyc(1, 1, 8'hB0 + 8'(i), OP_OR);
      chk("stream_count", 32'(count), 32'd2);
      for (int i = 0; i < 2; i++) cyc(0, 1, 8'h00, OP_ADD);

      // full with simultaneous push/pop: pop only
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'hC0 + 8'(i), OP_XOR);
      cyc(1, 1, 8'hD0, OP_NOT);
      chk("full_pp_count", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, OP_ADD);

      // random traffic; unsupported ops carry a zero result as from the ALU
      for (int i = 0; i < 60; i++) begin
         automatic logic [2:0] op = 3'($urandom_range(0, 7));
         automatic logic [7:0] res = (op[2] & op[1]) ? 8'h00 : 8'($urandom_range(0, 255));
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res, op);
      end
      while (!empty && q.size() > 0) cyc(0, 1, 8'h00, OP_ADD);
      cyc(0, 0, 8'h00, OP_ADD);

      // error op, then async reset at count 3
      cyc(1, 0, 8'h00, 3'b110);
      chk("err_flag", 32'(bus.out_err), 32'd1);
      chk("err_zero", 32'(bus.out_zero), 32'd1);
      cyc(1, 0, 8'h7F, OP_ADD);
      cyc(1, 0, 8'h00, 3'b111);
      bus.in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_out", 32'({bus.out_result, bus.out_op, bus.out_zero, bus.out_neg, bus.out_err}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1, 0, 8'h3C, OP_ADD);
      cyc(0, 1, 8'h00, OP_ADD);
      cyc(0, 0, 8'h00, OP_ADD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit combinational ALU. Captures each valid ALU result together with the opcode that produced it, and derives per-result status flags.
- Buffers entries in a small FIFO and presents them to the consumer (writeback/register-file stage) over a valid/ready handshake.
- Decouples consumer stalls from the ALU issue path.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result present this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_result  input  8  ALU result byte.
- in_op  input  3  opcode that produced in_result.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer takes head entry.
- out_result  output  8  head entry result.
- out_op  output  3  head entry opcode.
- out_zero  output  1  head result == 8'h00.
- out_neg  output  1  head result bit 7.
- out_err  output  1  head opcode was 3'b110 or 3'b111 (unsupported op).
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and count go to 0; empty=1, full=0.
  - out_valid=0, in_ready=1.
  - out_result, out_op, out_zero, out_neg and out_err are 0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all entries; no partial pop.
- Push: in_valid && in_ready at a clock edge.
  - Writes {in_result, in_op, zero, neg, err} at wr_ptr.
  - Flags are computed from the input bits at push time and stored.
  - wr_ptr increments, wrapping modulo DEPTH.
- Pop: out_valid && out_ready at a clock edge. rd_ptr increments, wrapping modulo DEPTH.
- Outputs are show-ahead: the head entry is driven from storage at rd_ptr, and the out_* data outputs are forced to 0 when empty.
- Latency: a push at edge N makes out_valid=1 from edge N (visible in cycle N+1). There is no same-cycle bypass from in_* to out_*.
- Simultaneous push and pop:
  - When neither full nor empty, count is unchanged and both pointers advance.
  - When full, in_ready=0, so only the pop occurs; there is no fall-through write to a slot freed in the same cycle.
  - When empty, only the push occurs.
- in_valid while full: the data is not captured, and the upstream holds it. The ALU is combinational, so the issue stage must keep operands stable.
- out_ready while empty: no effect.
- count: +1 on push only, -1 on pop only, unchanged otherwise. full and empty are decoded from count.
- Unsupported opcodes are stored and delivered, not dropped. out_err marks them; the ALU drives a 0 result for these opcodes, so out_zero is also 1.
- Opcode encodings: ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101.

Optional Feature:
- Macro: ALU_RES_FIFO_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit), the even parity of {out_op, out_result}.
  - The parity is computed at push and stored per entry; out_parity is 0 when empty.
- When undefined: the port and its storage bit are absent, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (ADD..NOT);
  - a typedef for the opcode (3-bit);
  - a packed struct alu_res_t {result, op, zero, neg, err}, with parity added under the macro.
- One sub-module is natural: alu_res_flags, a combinational flag/err(/parity) generator from {result, op}.
- Pointer/count logic stays in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release → empty=1, full=0, count=0, out_valid=0, in_ready=1, out_result=0.
- Single push: in_result=8'h80, in_op=000 at edge N → from cycle N+1: out_valid=1, out_result=8'h80, out_neg=1, out_zero=0, out_err=0, count=1. Pop with out_ready=1 → empty=1.
- Fill with out_ready=0, DEPTH=4: push 8'h01, 8'h02, 8'h03, 8'h04 → full=1, in_ready=0. A fifth push of 8'h05 is ignored. Draining yields 01, 02, 03, 04 in order.
- Simultaneous push/pop: at count=2, in_valid=1 and out_ready=1 for 6 cycles → count stays 2, both pointers wrap, and outputs appear in push order.
- Full plus simultaneous: at count=4, in_valid=1 and out_ready=1 → one pop only, count=3, and the pushed value is not stored that cycle.
- Error op and reset mid-stream:
  - Push in_op=3'b110 with in_result=8'h00 → out_err=1, out_zero=1.
  - Assert rst asynchronously at count=3 → outputs go to their reset values immediately, without waiting for a clock edge.
